// File: rtl/ps2_letter_decoder_pkg.sv
// Shared constants, types and helpers for the PS/2 letter decoder.
// Scan-code values follow PS/2 set 2; letter index 0 = A ... 25 = Z.
package enigma_kbd_pkg;

    localparam int N_LETTERS = 26;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ERR0  = 8'h00;
    localparam logic [7:0] SC_ERR1  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } kbd_state_e;

    typedef logic [4:0]           letter_idx_t;
    typedef logic [N_LETTERS-1:0] letter_oh_t;

    localparam logic [7:0] LETTER_CODES [N_LETTERS] = '{
        8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
        8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
        8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A
    };

    function automatic letter_oh_t idx_to_onehot(input letter_idx_t idx);
        return letter_oh_t'(1) << idx;
    endfunction

endpackage

// File: rtl/ps2_letter_decoder_if.sv
// Byte stream from the PS/2 receiver plus the decoded letter events.
// master = receiver/consumer side, slave = the decoder.
interface ps2_letter_decoder_if;
    import enigma_kbd_pkg::*;

    logic [7:0] scan_code;
    logic       scan_ready;
    logic       read;
    letter_oh_t letter;
    logic       letter_valid;
    logic       key_held;
    logic       err;

    modport master (
        output scan_code,
        output scan_ready,
        input  read,
        input  letter,
        input  letter_valid,
        input  key_held,
        input  err
    );

    modport slave (
        input  scan_code,
        input  scan_ready,
        output read,
        output letter,
        output letter_valid,
        output key_held,
        output err
    );

endinterface

// File: rtl/ps2_letter_decoder_lut.sv
// Combinational set-2 scan code to letter index lookup.
// Codes are unique, so at most one match bit is ever set.
module scan_letter_lut
    import enigma_kbd_pkg::*;
(
    input  logic [7:0]  scan_code_i,
    output logic        hit_o,
    output letter_idx_t idx_o
);

    logic [N_LETTERS-1:0] match;

    generate
        for (genvar gi = 0; gi < N_LETTERS; gi++) begin : g_match
            assign match[gi] = (scan_code_i == LETTER_CODES[gi]);
        end
    endgenerate

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < N_LETTERS; i++) begin
            if (match[i]) begin
                idx_o = letter_idx_t'(i);
            end
        end
    end

    assign hit_o = |match;

endmodule

// File: rtl/ps2_letter_decoder.sv
// PS/2 set-2 byte stream to one-hot letter events with break/extended prefix handling.
// Optional macro KBD_TYPEMATIC_EN: re-emit letter_valid on autorepeat of the held key.
module ps2_letter_decoder
    import enigma_kbd_pkg::*;
(
    input  logic                  CLOCK_50,
    input  logic                  reset,
    ps2_letter_decoder_if.slave   bus
);

    kbd_state_e  state_q, state_d;
    logic        ready_q;
    letter_oh_t  letter_q, letter_d;
    logic        letter_valid_q, letter_valid_d;
    logic        read_q, read_d;
    logic        err_q, err_d;
    logic        held_q, held_d;
    letter_idx_t held_idx_q, held_idx_d;

    logic        lut_hit;
    letter_idx_t lut_idx;
    logic        byte_edge;
    logic        is_err_code;
    logic        same_as_held;

    scan_letter_lut u_lut (
        .scan_code_i (bus.scan_code),
        .hit_o       (lut_hit),
        .idx_o       (lut_idx)
    );

    // Only the rising edge of the level counts; the receiver holds it high until acknowledged.
    assign byte_edge    = bus.scan_ready & ~ready_q;
    assign is_err_code  = (bus.scan_code == SC_ERR0) || (bus.scan_code == SC_ERR1);
    assign same_as_held = held_q && (lut_idx == held_idx_q);

    always_comb begin
        state_d        = state_q;
        letter_d       = letter_q;
        letter_valid_d = 1'b0;
        read_d         = 1'b0;
        err_d          = 1'b0;
        held_d         = held_q;
        held_idx_d     = held_idx_q;

        if (byte_edge) begin
            read_d = 1'b1;
            if (is_err_code) begin
                err_d      = 1'b1;
                held_d     = 1'b0;
                held_idx_d = '0;
                state_d    = ST_IDLE;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        if (bus.scan_code == SC_BREAK) begin
                            state_d = ST_BRK;
                        end else if (bus.scan_code == SC_EXT) begin
                            state_d = ST_EXT;
                        end else if (lut_hit) begin
                            if (!same_as_held) begin
                                letter_d       = idx_to_onehot(lut_idx);
                                letter_valid_d = 1'b1;
                                held_d         = 1'b1;
                                held_idx_d     = lut_idx;
                            end else begin
`ifdef KBD_TYPEMATIC_EN
                                letter_valid_d = 1'b1;
`endif
                            end
                        end
                    end
                    ST_BRK: begin
                        state_d = ST_IDLE;
                        // A break for a key that was superseded by rollover is ignored.
                        if (lut_hit && same_as_held) begin
                            held_d = 1'b0;
                        end
                    end
                    ST_EXT: begin
                        state_d = (bus.scan_code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                    end
                    ST_EXT_BRK: begin
                        state_d = ST_IDLE;
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            ready_q        <= 1'b0;
            letter_q       <= '0;
            letter_valid_q <= 1'b0;
            read_q         <= 1'b0;
            err_q          <= 1'b0;
            held_q         <= 1'b0;
            held_idx_q     <= '0;
        end else begin
            state_q        <= state_d;
            ready_q        <= bus.scan_ready;
            letter_q       <= letter_d;
            letter_valid_q <= letter_valid_d;
            read_q         <= read_d;
            err_q          <= err_d;
            held_q         <= held_d;
            held_idx_q     <= held_idx_d;
        end
    end

    assign bus.read         = read_q;
    assign bus.letter       = letter_q;
    assign bus.letter_valid = letter_valid_q;
    assign bus.key_held     = held_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_ps2_letter_decoder.sv
// Directed self-checking bench for ps2_letter_decoder; one line printed per byte sent.
module tb_ps2_letter_decoder;
    import enigma_kbd_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ps2_letter_decoder_if bus ();

    ps2_letter_decoder dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    int checks = 0;
    int failures = 0;

    int read_cnt = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    always @(negedge clk) begin
        if (bus.read === 1'b1)         read_cnt++;
        if (bus.letter_valid === 1'b1) valid_cnt++;
        if (bus.err === 1'b1)          err_cnt++;
    end

    logic       obs_read, obs_valid, obs_err, obs_held;
    letter_oh_t obs_letter;
    int         base_read, base_valid;

    // One byte: scan_ready high for one cycle, low for the next; outputs sampled on cycle n+1.
    task automatic send_byte(input logic [7:0] code);
        @(negedge clk);
        bus.scan_code  = code;
        bus.scan_ready = 1'b1;
        @(negedge clk);
        bus.scan_ready = 1'b0;
        obs_read   = bus.read;
        obs_valid  = bus.letter_valid;
        obs_err    = bus.err;
        obs_held   = bus.key_held;
        obs_letter = bus.letter;
        $display("byte %02h : read=%b valid=%b letter=%07h held=%b err=%b",
                 code, obs_read, obs_valid, obs_letter, obs_held, obs_err);
    endtask

    task automatic snap_counts();
        @(negedge clk);
        #1;
        base_read  = read_cnt;
        base_valid = valid_cnt;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.scan_code  = 8'h00;
        bus.scan_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.letter !== 26'h0 || bus.letter_valid !== 1'b0 || bus.read !== 1'b0 ||
            bus.err !== 1'b0 || bus.key_held !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: letter=%h valid=%b read=%b err=%b held=%b expected all 0",
                     bus.letter, bus.letter_valid, bus.read, bus.err, bus.key_held);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_make();
        send_byte(8'h1C);
        checks++;
        if (obs_read !== 1'b1 || obs_valid !== 1'b1) begin
            failures++;
            $display("FAIL make_A_strobes: read=%b valid=%b expected 1 1", obs_read, obs_valid);
        end
        checks++;
        if (obs_letter !== 26'h0000001) begin
            failures++;
            $display("FAIL make_A_letter: got %h expected 0000001", obs_letter);
        end
        checks++;
        if (obs_held !== 1'b1) begin
            failures++;
            $display("FAIL make_A_held: got %b expected 1", obs_held);
        end
        @(negedge clk);
        checks++;
        if (bus.read !== 1'b0 || bus.letter_valid !== 1'b0 || bus.letter !== 26'h0000001) begin
            failures++;
            $display("FAIL make_A_width: read=%b valid=%b letter=%h expected 0 0 0000001",
                     bus.read, bus.letter_valid, bus.letter);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        checks++;
        if (obs_held !== 1'b0) begin
            failures++;
            $display("FAIL release_A: held=%b expected 0", obs_held);
        end
    endtask

    task automatic test_break();
        snap_counts();
        send_byte(8'h1A);
        checks++;
        if (obs_letter !== 26'h2000000 || obs_valid !== 1'b1) begin
            failures++;
            $display("FAIL make_Z: letter=%h valid=%b expected 2000000 1", obs_letter, obs_valid);
        end
        send_byte(8'hF0);
        checks++;
        if (obs_held !== 1'b1) begin
            failures++;
            $display("FAIL held_after_F0: got %b expected 1", obs_held);
        end
        send_byte(8'h1A);
        checks++;
        if (obs_held !== 1'b0 || obs_valid !== 1'b0) begin
            failures++;
            $display("FAIL break_Z: held=%b valid=%b expected 0 0", obs_held, obs_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (valid_cnt - base_valid !== 1) begin
            failures++;
            $display("FAIL break_Z_count: valids=%0d expected 1", valid_cnt - base_valid);
        end
    endtask

    task automatic test_repeat();
        int exp_valid;
`ifdef KBD_TYPEMATIC_EN
        exp_valid = 3;
`else
        exp_valid = 1;
`endif
        snap_counts();
        send_byte(8'h1C);
        send_byte(8'h1C);
        send_byte(8'h1C);
        checks++;
        if (obs_letter !== 26'h0000001 || obs_held !== 1'b1) begin
            failures++;
            $display("FAIL repeat_letter: letter=%h held=%b expected 0000001 1", obs_letter, obs_held);
        end
        @(negedge clk); #1;
        checks++;
        if (valid_cnt - base_valid !== exp_valid) begin
            failures++;
            $display("FAIL repeat_valids: got %0d expected %0d", valid_cnt - base_valid, exp_valid);
        end
        checks++;
        if (read_cnt - base_read !== 3) begin
            failures++;
            $display("FAIL repeat_reads: got %0d expected 3", read_cnt - base_read);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
    endtask

    task automatic test_extended();
        snap_counts();
        send_byte(8'hE0);
        send_byte(8'h75);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        send_byte(8'h29);
        @(negedge clk); #1;
        checks++;
        if (valid_cnt - base_valid !== 0) begin
            failures++;
            $display("FAIL ext_valids: got %0d expected 0", valid_cnt - base_valid);
        end
        checks++;
        if (read_cnt - base_read !== 6) begin
            failures++;
            $display("FAIL ext_reads: got %0d expected 6", read_cnt - base_read);
        end
        // A letter now must be a make, proving the FSM is back in IDLE.
        send_byte(8'h1C);
        checks++;
        if (obs_valid !== 1'b1 || obs_letter !== 26'h0000001) begin
            failures++;
            $display("FAIL ext_back_idle: valid=%b letter=%h expected 1 0000001", obs_valid, obs_letter);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
    endtask

    task automatic test_rollover();
        send_byte(8'h1C);
        send_byte(8'h32);
        checks++;
        if (obs_valid !== 1'b1 || obs_letter !== 26'h0000002) begin
            failures++;
            $display("FAIL rollover_B: valid=%b letter=%h expected 1 0000002", obs_valid, obs_letter);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        checks++;
        if (obs_held !== 1'b1) begin
            failures++;
            $display("FAIL stale_break_A: held=%b expected 1", obs_held);
        end
        send_byte(8'hF0);
        send_byte(8'h32);
        checks++;
        if (obs_held !== 1'b0) begin
            failures++;
            $display("FAIL break_B: held=%b expected 0", obs_held);
        end
    endtask

    task automatic test_back_to_back();
        snap_counts();
        @(negedge clk);
        bus.scan_code  = 8'h21;
        bus.scan_ready = 1'b1;
        repeat (3) @(negedge clk);
        bus.scan_ready = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (read_cnt - base_read !== 1 || valid_cnt - base_valid !== 1) begin
            failures++;
            $display("FAIL level_held: reads=%0d valids=%0d expected 1 1",
                     read_cnt - base_read, valid_cnt - base_valid);
        end
        checks++;
        if (bus.letter !== 26'h0000004) begin
            failures++;
            $display("FAIL level_letter_C: got %h expected 0000004", bus.letter);
        end
        send_byte(8'hF0);
        send_byte(8'h21);
    endtask

    task automatic test_reset_mid_prefix();
        send_byte(8'hF0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (bus.key_held !== 1'b0 || bus.letter !== 26'h0) begin
            failures++;
            $display("FAIL async_reset: held=%b letter=%h expected 0 0", bus.key_held, bus.letter);
        end
        @(negedge clk);
        reset = 1'b1;
        send_byte(8'h1C);
        checks++;
        if (obs_valid !== 1'b1 || obs_held !== 1'b1) begin
            failures++;
            $display("FAIL prefix_discard: valid=%b held=%b expected 1 1", obs_valid, obs_held);
        end
        send_byte(8'hFF);
        checks++;
        if (obs_err !== 1'b1 || obs_held !== 1'b0 || obs_read !== 1'b1 || obs_valid !== 1'b0) begin
            failures++;
            $display("FAIL err_FF: err=%b held=%b read=%b valid=%b expected 1 0 1 0",
                     obs_err, obs_held, obs_read, obs_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.err !== 1'b0) begin
            failures++;
            $display("FAIL err_width: err=%b expected 0", bus.err);
        end
        // Error inside a prefix also returns to IDLE: the next letter is a make.
        send_byte(8'hF0);
        send_byte(8'h00);
        send_byte(8'h32);
        checks++;
        if (obs_valid !== 1'b1 || obs_letter !== 26'h0000002) begin
            failures++;
            $display("FAIL err_in_prefix: valid=%b letter=%h expected 1 0000002", obs_valid, obs_letter);
        end
    endtask

    initial begin
        bus.scan_code  = 8'h00;
        bus.scan_ready = 1'b0;
        test_reset();
        test_single_make();
        test_break();
        test_repeat();
        test_extended();
        test_rollover();
        test_back_to_back();
        test_reset_mid_prefix();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_letter_decoder.md
# ps2_letter_decoder

Turns the raw PS/2 set-2 scan-code byte stream from the keyboard receiver into clean letter events for the Enigma datapath. It sits between the PS/2 receiver and the plugboard stage, which takes a one-hot 26-bit letter. The block handles break (`F0`) and extended (`E0`) prefixes and drops non-letter keys. It emits exactly one validated one-hot letter per physical key press, and it acknowledges every received byte back to the receiver, so no external one-shot is needed.

## Interface
- Parameters: none.
- Ports:
  - `CLOCK_50  in  1`  system clock; the only clock.
  - `reset  in  1`  asynchronous, active-low reset.
  - `scan_code  in  8`  byte from the PS/2 receiver; stable while `scan_ready` is high.
  - `scan_ready  in  1`  receiver byte-available level, synchronous to `CLOCK_50`.
  - `read  out  1`  one-cycle acknowledge to the receiver, one per accepted byte.
  - `letter  out  26`  one-hot letter; A = bit 0 … Z = bit 25; holds its last value.
  - `letter_valid  out  1`  one-cycle strobe; `letter` is new this cycle.
  - `key_held  out  1`  high while the last emitted letter's key is down.
  - `err  out  1`  one-cycle strobe on a receiver overflow/error code.

## Operation
- **Byte accept:** a byte is accepted on a rising edge of `scan_ready` (high now, low in the registered copy). Level-high cycles after the edge are ignored.
- **FSM states:**
  - IDLE
  - BRK (after `F0`)
  - EXT (after `E0`)
  - EXT_BRK (after `E0 F0`)
- **IDLE transitions:**
  - `F0` → BRK.
  - `E0` → EXT.
  - `00` or `FF` → `err` strobe, clear held, stay IDLE.
  - Letter code → make handling.
  - Any other code → ignored.
- **BRK:** any byte → IDLE. If the byte is a letter code equal to the held letter, clear `key_held`. Otherwise no effect.
- **EXT:**
  - `F0` → EXT_BRK.
  - Any other byte → IDLE, ignored (extended keys are never letters).
- **EXT_BRK:** any byte → IDLE, ignored.
- **Make handling:**
  - New letter, or no key held: register the one-hot code in `letter`, pulse `letter_valid`, set `key_held`, record the held index.
  - Same letter as held (typematic repeat): behaviour set by `KBD_TYPEMATIC_EN` (see Configuration).
  - Different letter while another is held: emit it and replace the held index. The old key's later break is then ignored.
- `00`/`FF` received in any state → `err`, clear held, → IDLE.
- **Reset** (any time, including mid-prefix):
  - State IDLE; `letter` = 0; `letter_valid`, `read`, `err`, `key_held` = 0.
  - Held index cleared; edge-detect register cleared.
  - A partial prefix is discarded.

## Timing
- A byte accepted on edge cycle n gives `read`, and any `letter_valid`/`err`, on cycle n+1, each exactly one cycle wide.
- `letter` updates in the same cycle as `letter_valid`.
- `key_held` changes on cycle n+1.
- Maximum throughput is one byte per two cycles. `scan_ready` must be low for at least one cycle between bytes.
- A `scan_ready` edge arriving in the same cycle as a `read` pulse is accepted normally.
- Outputs are all registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro `KBD_TYPEMATIC_EN`:
  - **Defined:** a repeated make of the held letter re-emits `letter_valid` with the same `letter`, modelling autorepeat.
  - **Undefined (default):** repeats are silently absorbed; no `letter_valid` until that key is released and pressed again.

## Structure
- Package `enigma_kbd_pkg`:
  - `N_LETTERS` = 26.
  - Scan-code constants `SC_BREAK` = `8'hF0`, `SC_EXT` = `8'hE0`, `SC_ERR0` = `8'h00`, `SC_ERR1` = `8'hFF`.
  - FSM state enum.
  - 5-bit letter-index typedef.
  - Set-2 letter codes, A–Z: 1C 32 21 23 24 2B 34 33 43 3B 42 4B 3A 31 44 4D 15 2D 1B 2C 3C 2A 1D 22 35 1A.
- Sub-module `scan_letter_lut`: combinational; takes `scan_code` and returns a hit flag plus the 5-bit index. The top converts the index to one-hot.

## Test plan
- Reset, then byte `1C` → `read` and `letter_valid` on n+1; `letter` = `26'h0000001`; `key_held` = 1.
- `1A`, `F0`, `1A` → one `letter_valid` with `letter` = `26'h2000000`; `key_held` drops on the third byte's n+1.
- `1C`, `1C`, `1C` with the macro undefined → 1 `letter_valid`; with `KBD_TYPEMATIC_EN` → 3. `read` pulses 3 times in both builds.
- `E0`, `75`, `E0`, `F0`, `75` (arrow key) and `29` (space) → no `letter_valid`; 6 `read` pulses; state returns to IDLE.
- `1C`, then `32` while A is still held → second `letter_valid` with `letter` = `26'h0000002`. Then `F0`, `1C` leaves `key_held` = 1; `F0`, `32` clears it.
- `F0` then `reset` asserted, then released, then `1C` → `1C` is treated as a make (`letter_valid`), not a break. Separately, byte `FF` → `err` pulse and `key_held` = 0.
